// File: rtl/uart_frame_decoder_pkg.sv
// Shared UART constants and types for the frame decoder.
//   - Baud timing constants (50 MHz system clock, 115200 baud).
//   - Default frame header byte and default inter-byte gap limit.
//   - Decoder state encoding and abort-cause codes.
package uart_frame_decoder_pkg;

   localparam int unsigned CLK_HZ     = 50_000_000;
   localparam int unsigned BAUD       = 115_200;
   localparam int unsigned BIT_CYCLES = CLK_HZ / BAUD;   // 434 sclk cycles per bit
   localparam int unsigned GAP_BITS   = 20;               // allowed idle time inside a frame, in bit times

   // Last counter value before a gap timeout: 20 bit times minus one.
   localparam int unsigned GAP_END_DEFAULT = BIT_CYCLES * GAP_BITS - 1;

   localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CMD  = 3'd1,
      ST_ADDR = 3'd2,
      ST_DATH = 3'd3,
      ST_DATL = 3'd4,
      ST_CHK  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CHK  = 2'd1,
      ERR_GAP  = 2'd2
   } err_e;

endpackage

// File: rtl/uart_frame_decoder_gap_timer.sv
// uart_gap_timer: idle-time watchdog for bytes inside a frame.
//   sclk, s_rst_n : clock, asynchronous active-low reset
//   clr           : a byte arrived this cycle; restart the count
//   en            : decoder is inside a frame; count idle cycles
//   expire        : one-cycle pulse, counter sits at GAP_END and no byte arrived
module uart_gap_timer
   import uart_frame_decoder_pkg::*;
#(
   parameter int unsigned GAP_END = GAP_END_DEFAULT
) (
   input  logic sclk,
   input  logic s_rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [15:0] END_CNT = 16'(GAP_END);

   logic [15:0] cnt_q, cnt_d;
   logic        at_end;

   // NOTE: every variable assigned in always_comb gets a value on every path
   // (here via the leading default) so no latch is inferred.
   always_comb begin
      at_end = (cnt_q == END_CNT);
      cnt_d  = cnt_q + 16'd1;
      // Outside a frame the count parks at zero; a byte always restarts it,
      // and an expiry restarts it so the next frame sees a fresh count.
      if (clr || !en || at_end) begin
         cnt_d = '0;
      end
   end

   // A byte arriving in the expiry cycle wins over the timeout.
   assign expire = en && !clr && at_end;

   // NOTE: sequential state is updated with non-blocking assignments only,
   // so every flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: parses HEADER, CMD, ADDR, DATA_H, DATA_L, CHK frames
// from a byte stream and publishes the fields of each frame whose checksum
// (8-bit sum of the four payload bytes) matches.
//   sclk, s_rst_n      : clock, asynchronous active-low reset
//   rx_data, po_flag   : received byte and its one-cycle valid strobe
//   cmd_valid          : one-cycle pulse, good frame decoded
//   cmd_code/addr/data : fields of the last good frame
//   frame_err          : one-cycle pulse, frame aborted
//   err_code           : cause of the last abort (checksum or gap timeout)
//   busy               : decoder is inside a frame
module uart_frame_decoder
   import uart_frame_decoder_pkg::*;
#(
   parameter logic [7:0]  HEADER  = HEADER_DEFAULT,
   parameter int unsigned GAP_END = GAP_END_DEFAULT
) (
   input  logic        sclk,
   input  logic        s_rst_n,
   input  logic [7:0]  rx_data,
   input  logic        po_flag,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic [7:0]  cmd_addr,
   output logic [15:0] cmd_data,
   output logic        frame_err,
   output logic [1:0]  err_code,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  code_sh_q, code_sh_d;
   logic [7:0]  addr_sh_q, addr_sh_d;
   logic [7:0]  dath_sh_q, dath_sh_d;
   logic [7:0]  datl_sh_q, datl_sh_d;
   logic [7:0]  cmd_code_q, cmd_code_d;
   logic [7:0]  cmd_addr_q, cmd_addr_d;
   logic [15:0] cmd_data_q, cmd_data_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        frame_err_q, frame_err_d;
   err_e        err_code_q, err_code_d;
   logic        gap_expire;

   uart_gap_timer #(
      .GAP_END (GAP_END)
   ) u_gap_timer (
      .sclk    (sclk),
      .s_rst_n (s_rst_n),
      .clr     (po_flag),
      .en      (state_q != ST_IDLE),
      .expire  (gap_expire)
   );

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      code_sh_d   = code_sh_q;
      addr_sh_d   = addr_sh_q;
      dath_sh_d   = dath_sh_q;
      datl_sh_d   = datl_sh_q;
      cmd_code_d  = cmd_code_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_data_d  = cmd_data_q;
      cmd_valid_d = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;

      if (po_flag) begin
         // Payload bytes, including ones equal to HEADER, go into the
         // shadow registers and the running sum; only IDLE looks for HEADER.
         case (state_q)
            ST_IDLE: begin
               if (rx_data == HEADER) begin
                  state_d = ST_CMD;
                  sum_d   = '0;
               end
            end
            ST_CMD: begin
               code_sh_d = rx_data;
               sum_d     = sum_q + rx_data;
               state_d   = ST_ADDR;
            end
            ST_ADDR: begin
               addr_sh_d = rx_data;
               sum_d     = sum_q + rx_data;
               state_d   = ST_DATH;
            end
            ST_DATH: begin
               dath_sh_d = rx_data;
               sum_d     = sum_q + rx_data;
               state_d   = ST_DATL;
            end
            ST_DATL: begin
               datl_sh_d = rx_data;
               sum_d     = sum_q + rx_data;
               state_d   = ST_CHK;
            end
            ST_CHK: begin
               state_d = ST_IDLE;
               if (rx_data == sum_q) begin
                  cmd_valid_d = 1'b1;
                  cmd_code_d  = code_sh_q;
                  cmd_addr_d  = addr_sh_q;
                  cmd_data_d  = {dath_sh_q, datl_sh_q};
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (gap_expire) begin
         state_d     = ST_IDLE;
         frame_err_d = 1'b1;
         err_code_d  = ERR_GAP;
      end
   end

   // NOTE: the shadow and output registers are plain flops, not a memory,
   // so they take the asynchronous reset like every other piece of state.
   always_ff @(posedge sclk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         state_q     <= ST_IDLE;
         sum_q       <= '0;
         code_sh_q   <= '0;
         addr_sh_q   <= '0;
         dath_sh_q   <= '0;
         datl_sh_q   <= '0;
         cmd_code_q  <= '0;
         cmd_addr_q  <= '0;
         cmd_data_q  <= '0;
         cmd_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         code_sh_q   <= code_sh_d;
         addr_sh_q   <= addr_sh_d;
         dath_sh_q   <= dath_sh_d;
         datl_sh_q   <= datl_sh_d;
         cmd_code_q  <= cmd_code_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_data_q  <= cmd_data_d;
         cmd_valid_q <= cmd_valid_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_code  = cmd_code_q;
   assign cmd_addr  = cmd_addr_q;
   assign cmd_data  = cmd_data_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   // Drops together with the cmd_valid / frame_err pulse, since the state
   // returns to IDLE on the same edge that registers the pulse.
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Self-checking bench for uart_frame_decoder. A frame-level reference model
// (byte position within a frame, arithmetic checksum, idle-cycle count since
// the last byte) predicts every output after every clock.
module tb_uart_frame_decoder;

   localparam logic [7:0] HDR = 8'hAA;
   localparam int         G   = 30;   // short gap limit to keep the run brief

   logic        sclk;
   logic        s_rst_n;
   logic [7:0]  rx_data;
   logic        po_flag;
   logic        cmd_valid;
   logic [7:0]  cmd_code;
   logic [7:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        frame_err;
   logic [1:0]  err_code;
   logic        busy;

   uart_frame_decoder #(
      .HEADER  (HDR),
      .GAP_END (G)
   ) dut (
      .sclk      (sclk),
      .s_rst_n   (s_rst_n),
      .rx_data   (rx_data),
      .po_flag   (po_flag),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .frame_err (frame_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   initial begin
      sclk = 1'b0;
      forever #5 sclk = ~sclk;
   end

   int total = 0;
   int bad   = 0;

   // Reference model state.
   bit          m_in_frame;
   int          m_nb;          // payload bytes collected so far
   int          m_fb [4];      // CMD, ADDR, DATA_H, DATA_L
   int          m_idle;        // idle cycles since the last byte
   logic        e_valid;
   logic        e_ferr;
   logic [1:0]  e_err;
   logic [7:0]  e_code;
   logic [7:0]  e_addr;
   logic [15:0] e_data;

   logic [7:0]  fr [6];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(e_valid));
      check({tag, ".frame_err"}, 32'(frame_err), 32'(e_ferr));
      check({tag, ".err_code"},  32'(err_code),  32'(e_err));
      check({tag, ".cmd_code"},  32'(cmd_code),  32'(e_code));
      check({tag, ".cmd_addr"},  32'(cmd_addr),  32'(e_addr));
      check({tag, ".cmd_data"},  32'(cmd_data),  32'(e_data));
      check({tag, ".busy"},      32'(busy),      32'(m_in_frame));
   endtask

   function automatic logic [7:0] chk_of(input logic [7:0] c, input logic [7:0] a,
                                         input logic [7:0] h, input logic [7:0] l);
      return 8'((int'(c) + int'(a) + int'(h) + int'(l)) % 256);
   endfunction

   task automatic model_reset();
      m_in_frame = 1'b0;
      m_nb       = 0;
      m_idle     = 0;
      e_valid    = 1'b0;
      e_ferr     = 1'b0;
      e_err      = 2'd0;
      e_code     = 8'h00;
      e_addr     = 8'h00;
      e_data     = 16'h0000;
   endtask

   task automatic model_byte(input logic [7:0] b);
      int s;
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      m_idle  = 0;
      if (!m_in_frame) begin
         if (b == HDR) begin
            m_in_frame = 1'b1;
            m_nb       = 0;
         end
      end else if (m_nb < 4) begin
         m_fb[m_nb] = int'(b);
         m_nb++;
      end else begin
         m_in_frame = 1'b0;
         s = (m_fb[0] + m_fb[1] + m_fb[2] + m_fb[3]) % 256;
         if (int'(b) == s) begin
            e_valid = 1'b1;
            e_code  = 8'(m_fb[0]);
            e_addr  = 8'(m_fb[1]);
            e_data  = 16'(m_fb[2] * 256 + m_fb[3]);
         end else begin
            e_ferr = 1'b1;
            e_err  = 2'd1;
         end
      end
   endtask

   task automatic model_idle();
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      if (m_in_frame) begin
         m_idle++;
         if (m_idle == G + 1) begin
            m_in_frame = 1'b0;
            e_ferr     = 1'b1;
            e_err      = 2'd2;
         end
      end
   endtask

   // Present one byte for one cycle, then check the registered response.
   task automatic send(input logic [7:0] b);
      rx_data = b;
      po_flag = 1'b1;
      @(posedge sclk);
      #1;
      po_flag = 1'b0;
      rx_data = 8'($urandom);
      model_byte(b);
      check_all("byte");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge sclk);
         #1;
         model_idle();
         check_all("idle");
      end
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] h,
                             input logic [7:0] l, input logic [7:0] k, input int gap);
      send(HDR);  idle(gap);
      send(c);    idle(gap);
      send(a);    idle(gap);
      send(h);    idle(gap);
      send(l);    idle(gap);
      send(k);
   endtask

   task automatic do_reset();
      s_rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(posedge sclk);
      #1;
      check_all("rst_hold");
      s_rst_n = 1'b1;
      @(posedge sclk);
      #1;
      model_idle();
      check_all("rst_release");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      s_rst_n = 1'b1;
      po_flag = 1'b0;
      rx_data = 8'h00;
      model_reset();
      #2;
      do_reset();

      // Good frame.
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h57, 2);
      check("req034_valid", 32'(cmd_valid), 32'd1);
      check("req034_code",  32'(cmd_code),  32'h01);
      check("req034_addr",  32'(cmd_addr),  32'h10);
      check("req034_data",  32'(cmd_data),  32'h1234);
      idle(3);

      // Bad checksum: error pulse, previous command preserved.
      send_frame(8'h01, 8'h10, 8'h12, 8'h34, 8'h58, 1);
      check("req035_ferr",  32'(frame_err), 32'd1);
      check("req035_err",   32'(err_code),  32'd1);
      check("req035_data",  32'(cmd_data),  32'h1234);
      idle(2);

      // Sum wraps modulo 256, then stray bytes in IDLE are ignored.
      send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC, 0);
      check("req036_valid", 32'(cmd_valid), 32'd1);
      idle(1);
      send(8'h00);
      send(8'h55);
      check("req036_busy",  32'(busy),      32'd0);
      idle(2);

      // Gap timeout after two bytes, then a clean frame.
      send(HDR);
      send(8'h02);
      idle(G + 1);
      check("req037_ferr",  32'(frame_err), 32'd1);
      check("req037_err",   32'(err_code),  32'd2);
      check("req037_busy",  32'(busy),      32'd0);
      idle(2);
      send_frame(8'h21, 8'h42, 8'h00, 8'hFF, chk_of(8'h21, 8'h42, 8'h00, 8'hFF), 3);
      check("req037_next",  32'(cmd_code),  32'h21);
      idle(2);

      // Reset mid-frame discards the partial frame quietly.
      send(HDR);
      send(8'h01);
      send(8'h10);
      do_reset();
      send_frame(8'h03, 8'h04, 8'h00, 8'h01, 8'h08, 1);
      check("req038_code",  32'(cmd_code),  32'h03);
      check("req038_addr",  32'(cmd_addr),  32'h04);
      check("req038_data",  32'(cmd_data),  32'h0001);
      idle(2);

      // Every byte lands exactly in the expiry cycle: no timeout.
      send_frame(8'h11, 8'h22, 8'h33, 8'h44, chk_of(8'h11, 8'h22, 8'h33, 8'h44), G);
      check("req039_valid", 32'(cmd_valid), 32'd1);
      idle(2);

      // HEADER value as payload, then back-to-back frames with no gap.
      send_frame(HDR, HDR, 8'h00, 8'h00, 8'h54, 0);
      check("hdr_as_data",  32'(cmd_valid), 32'd1);
      send_frame(8'h05, 8'h06, 8'h07, 8'h08, 8'h1A, 0);
      check("b2b_valid",    32'(cmd_valid), 32'd1);
      send_frame(8'h09, 8'h0A, 8'hBE, 8'hEF, chk_of(8'h09, 8'h0A, 8'hBE, 8'hEF), 0);
      check("b2b_data",     32'(cmd_data),  32'hBEEF);
      idle(2);

      // Random frames with random gaps, noise, corrupted checksums, timeouts.
      for (int f = 0; f < 40; f++) begin
         int nnoise;
         nnoise = int'($urandom_range(0, 2));
         for (int n = 0; n < nnoise; n++) begin
            send(8'($urandom));
            idle(int'($urandom_range(0, 3)));
         end
         fr[0] = HDR;
         for (int k = 1; k < 5; k++) fr[k] = 8'($urandom);
         fr[5] = chk_of(fr[1], fr[2], fr[3], fr[4]);
         if ($urandom_range(0, 3) == 0) fr[5] = fr[5] ^ (8'd1 << $urandom_range(0, 7));
         for (int k = 0; k < 6; k++) begin
            send(fr[k]);
            if ($urandom_range(0, 15) == 0) idle(G + 1 + int'($urandom_range(0, 2)));
            else idle(int'($urandom_range(0, G)));
         end
      end
      idle(G + 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
